// File: rtl/line_bus_adapter.sv
// Cache-line to 32-bit word-bus adapter: splits a 128-bit line transfer into four word beats.
// Optional per-beat acknowledge timeout with a sticky bus_err output when LINE_BUS_TIMEOUT_EN is defined.
module line_bus_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic         bus_req,
  output logic         bus_we,
  output logic [29:0]  bus_addr,
  output logic [31:0]  bus_wdata,
  input  logic [31:0]  bus_rdata,
  input  logic         bus_ack
`ifdef LINE_BUS_TIMEOUT_EN
  ,
  output logic         bus_err
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BEAT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        beat_inc;
  logic [27:0]       line_q, line_d;
  logic [3:0][31:0]  wline_q, wline_d;
  logic [3:0][31:0]  rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [29:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  // Effective beat completion and the word to store for it.
  logic              beat_ack;
  logic [31:0]       ack_word;

  assign beat_inc  = beat_q + 2'd1;

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

`ifdef LINE_BUS_TIMEOUT_EN
  localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
  logic       timeout;

  // A beat that has waited TIMEOUT_CYCLES cycles is forced to complete with a zero word.
  assign timeout  = (state_q == BEAT) && !bus_ack && (wait_q == WaitLast);
  assign beat_ack = bus_ack || timeout;
  assign ack_word = bus_ack ? bus_rdata : 32'h0;
  assign bus_err  = err_q;

  always_comb begin
    wait_d = 8'd0;
    err_d  = err_q | timeout;
    if (state_q == BEAT && !beat_ack) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      wait_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
`else
  assign beat_ack = bus_ack;
  assign ack_word = bus_rdata;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    wline_d = wline_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          line_d  = mem_addr;
          wline_d = mem_wdata;
          we_d    = mem_write;
          beat_d  = 2'd0;
          req_d   = 1'b1;
          addr_d  = {mem_addr, 2'b00};
          wdata_d = mem_wdata[31:0];
          state_d = BEAT;
        end
      end
      BEAT: begin
        if (beat_ack) begin
          if (!we_q) begin
            rdata_d[beat_q] = ack_word;
          end
          if (beat_q == 2'd3) begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            ready_d = 1'b1;
            state_d = RESP;
          end else begin
            // Next beat presented immediately so beats run back to back.
            beat_d  = beat_inc;
            addr_d  = {line_q, beat_inc};
            wdata_d = wline_q[beat_inc];
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      line_q  <= 28'd0;
      wline_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 30'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      wline_q <= wline_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_line_bus_adapter.sv
// Scoreboard bench for line_bus_adapter: directed line transfers, expected beats/lines queued
// at issue time and compared by a separate monitor.
module tb_line_bus_adapter;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         bus_req;
  logic         bus_we;
  logic [29:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic [31:0]  bus_rdata;
  logic         bus_ack;
`ifdef LINE_BUS_TIMEOUT_EN
  logic         bus_err;
`endif

  always #5 clk = ~clk;

  line_bus_adapter #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack)
`ifdef LINE_BUS_TIMEOUT_EN
    ,
    .bus_err    (bus_err)
`endif
  );

  typedef struct {
    logic [29:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  beat_t        beat_exp[$];
  logic [127:0] line_exp[$];

  int checks   = 0;
  int failures = 0;

  // Bus slave: 0 = ack tied high, 1 = ack after 2 wait cycles, 2 = never ack beat 1.
  int          mode = 0;
  int          cnt  = 0;
  logic [31:0] rd_tbl [4];
  int          b1_cycles = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [29:0] a, input logic we, input logic [31:0] d);
    beat_t b;
    b.addr  = a;
    b.we    = we;
    b.wdata = d;
    beat_exp.push_back(b);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (mem_ready) break;
    end
    if (!mem_ready) chk("ready_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    logic prev;
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      prev = bus_ack;
      case (mode)
        0: bus_ack = 1'b1;
        1: begin
          if (prev || !bus_req) begin
            bus_ack = 1'b0;
            cnt     = 0;
          end else if (cnt == 2) begin
            bus_ack = 1'b1;
          end else begin
            cnt++;
          end
        end
        default: bus_ack = (bus_addr[1:0] != 2'd1);
      endcase
      bus_rdata = rd_tbl[bus_addr[1:0]];
    end
  end

  // Monitor: every acknowledged beat and every completion pulse pops one expectation.
  initial begin
    beat_t b;
    logic [127:0] l;
    forever begin
      @(negedge clk);
      if (!proc_reset && bus_req && bus_addr[1:0] == 2'd1 && !bus_ack) b1_cycles++;
      if (!proc_reset && bus_req && bus_ack) begin
        if (beat_exp.size() == 0) begin
          chk("unexpected_beat", {98'd0, bus_addr}, 128'd0);
        end else begin
          b = beat_exp.pop_front();
          chk("beat_addr", {98'd0, bus_addr}, {98'd0, b.addr});
          chk("beat_we", {127'd0, bus_we}, {127'd0, b.we});
          if (b.we) chk("beat_wdata", {96'd0, bus_wdata}, {96'd0, b.wdata});
        end
      end
      if (mem_ready) begin
        if (line_exp.size() == 0) begin
          chk("unexpected_ready", 128'd1, 128'd0);
        end else begin
          l = line_exp.pop_front();
          chk("line_rdata", mem_rdata, l);
        end
      end
    end
  end

  initial begin
    int n;
    proc_reset = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 28'd0;
    mem_wdata  = 128'd0;
    rd_tbl[0] = 32'h11111111; rd_tbl[1] = 32'h22222222;
    rd_tbl[2] = 32'h33333333; rd_tbl[3] = 32'h44444444;

    @(posedge clk);
    @(negedge clk);
    chk("rst_mem_ready", {127'd0, mem_ready}, 128'd0);
    chk("rst_bus_req", {127'd0, bus_req}, 128'd0);
    chk("rst_bus_we", {127'd0, bus_we}, 128'd0);
    chk("rst_bus_addr", {98'd0, bus_addr}, 128'd0);
    chk("rst_bus_wdata", {96'd0, bus_wdata}, 128'd0);
    chk("rst_mem_rdata", mem_rdata, 128'd0);
    @(posedge clk); #1 proc_reset = 1'b0;

    // Line read, ack tied high.
    push_beat(30'h40, 1'b0, 32'h0);
    push_beat(30'h41, 1'b0, 32'h0);
    push_beat(30'h42, 1'b0, 32'h0);
    push_beat(30'h43, 1'b0, 32'h0);
    line_exp.push_back(128'h44444444_33333333_22222222_11111111);
    @(posedge clk); #1;
    mem_read = 1'b1;
    mem_addr = 28'h0000010;
    wait_ready(n);
    chk("read_latency", 128'(n), 128'd6);
    @(posedge clk); #1;
    mem_read = 1'b0;
    mode     = 1;
    @(negedge clk);
    chk("ready_one_cycle", {127'd0, mem_ready}, 128'd0);

    // Line write with 2-cycle ack delay; inputs scrambled after acceptance.
    push_beat(30'h3C, 1'b1, 32'hAAAAAAAA);
    push_beat(30'h3D, 1'b1, 32'hBBBBBBBB);
    push_beat(30'h3E, 1'b1, 32'hCCCCCCCC);
    push_beat(30'h3F, 1'b1, 32'hDDDDDDDD);
    line_exp.push_back(128'h44444444_33333333_22222222_11111111);
    @(posedge clk); #1;
    mem_write = 1'b1;
    mem_addr  = 28'h000000F;
    mem_wdata = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    @(posedge clk); #1;
    mem_addr  = 28'hFFFFFFF;
    mem_wdata = {4{32'h12345678}};
    wait_ready(n);

    // Back-to-back refill in the cycle after RESP.
    push_beat(30'h048D159C, 1'b0, 32'h0);
    push_beat(30'h048D159D, 1'b0, 32'h0);
    push_beat(30'h048D159E, 1'b0, 32'h0);
    push_beat(30'h048D159F, 1'b0, 32'h0);
    line_exp.push_back(128'h88888888_77777777_66666666_55555555);
    @(posedge clk); #1;
    mem_write = 1'b0;
    mem_read  = 1'b1;
    mem_addr  = 28'h1234567;
    mode      = 0;
    rd_tbl[0] = 32'h55555555; rd_tbl[1] = 32'h66666666;
    rd_tbl[2] = 32'h77777777; rd_tbl[3] = 32'h88888888;
    wait_ready(n);
    chk("b2b_latency", 128'(n), 128'd6);
    @(posedge clk); #1;
    mem_read = 1'b0;
    mode     = 1;
    @(negedge clk);
    chk("b2b_one_cycle", {127'd0, mem_ready}, 128'd0);

    // Reset during beat 2 of a read.
    push_beat(30'h80, 1'b0, 32'h0);
    push_beat(30'h81, 1'b0, 32'h0);
    @(posedge clk); #1;
    mem_read = 1'b1;
    mem_addr = 28'h0000020;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_req && bus_addr[1:0] == 2'd2) begin
        n = 1;
        break;
      end
    end
    chk("reach_beat2", 128'(n), 128'd1);
    @(posedge clk); #1;
    proc_reset = 1'b1;
    mem_read   = 1'b0;
    @(negedge clk);
    chk("abort_ready", {127'd0, mem_ready}, 128'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_bus_req", {127'd0, bus_req}, 128'd0);
    chk("abort_rdata", mem_rdata, 128'd0);
    @(posedge clk); #1 proc_reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_ready", {127'd0, mem_ready}, 128'd0);

`ifdef LINE_BUS_TIMEOUT_EN
    // Beat 1 never acknowledged: forced completion after 8 cycles with a zero word.
    chk("err_clear", {127'd0, bus_err}, 128'd0);
    rd_tbl[0] = 32'h99999999; rd_tbl[1] = 32'h22222222;
    rd_tbl[2] = 32'hBBBBBBBB; rd_tbl[3] = 32'hCCCCCCCC;
    push_beat(30'hC0, 1'b0, 32'h0);
    push_beat(30'hC2, 1'b0, 32'h0);
    push_beat(30'hC3, 1'b0, 32'h0);
    line_exp.push_back(128'hCCCCCCCC_BBBBBBBB_00000000_99999999);
    @(posedge clk); #1;
    mode      = 2;
    b1_cycles = 0;
    mem_read  = 1'b1;
    mem_addr  = 28'h0000030;
    wait_ready(n);
    @(posedge clk); #1 mem_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("beat1_wait", 128'(b1_cycles), 128'd8);
    chk("err_sticky", {127'd0, bus_err}, 128'd1);
    @(posedge clk); #1 proc_reset = 1'b1;
    @(posedge clk); #1 proc_reset = 1'b0;
    @(negedge clk);
    chk("err_reset", {127'd0, bus_err}, 128'd0);
`endif

    repeat (3) @(negedge clk);
    chk("beats_left", 128'(beat_exp.size()), 128'd0);
    chk("lines_left", 128'(line_exp.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_bus_adapter.md
LINE_BUS_ADAPTER -- requirements
Module: line_bus_adapter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles bus_req waits for bus_ack on one beat (8-bit counter range, 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port proc_reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port mem_read  input  1  cache line-read request, held until mem_ready.
REQ-005 SHALL have port mem_write  input  1  cache line-write request, held until mem_ready.
REQ-006 SHALL have port mem_addr  input  28  line address.
REQ-007 SHALL have port mem_wdata  input  128  write line; word i is bits [32i+31:32i].
REQ-008 SHALL have port mem_rdata  output  128  assembled read line, registered.
REQ-009 SHALL have port mem_ready  output  1  registered one-cycle completion pulse.
REQ-010 SHALL have port bus_req  output  1  word-bus request.
REQ-011 SHALL have port bus_we  output  1  word-bus write enable.
REQ-012 SHALL have port bus_addr  output  30  word address = {latched line address, beat[1:0]}.
REQ-013 SHALL have port bus_wdata  output  32  write word for the current beat.
REQ-014 SHALL have port bus_rdata  input  32  read word, valid while bus_ack is high.
REQ-015 SHALL have port bus_ack  input  1  one-cycle beat acknowledge.

Function
REQ-016 SHALL implement states IDLE, BEAT, RESP.
REQ-017 In IDLE, with mem_read or mem_write high, SHALL latch mem_addr, mem_wdata, and direction (write wins if both are high), clear beat to 0, and enter BEAT; bus_req rises on the next cycle.
REQ-018 In BEAT, SHALL hold bus_req=1, with bus_we, bus_addr, and bus_wdata stable, until bus_ack is sampled high.
REQ-019 On bus_ack with a read, SHALL capture bus_rdata into mem_rdata word[beat].
REQ-020 On bus_ack with beat<3, SHALL increment beat; bus_req stays high and the next address appears the following cycle, with no idle cycle between beats.
REQ-021 On bus_ack with beat==3, SHALL drop bus_req and enter RESP.
REQ-022 In RESP, SHALL drive mem_ready=1 for exactly one cycle, then return to IDLE.
REQ-023 In the cycle after RESP, SHALL accept a new request, supporting back-to-back write-back then refill.
REQ-024 With an acknowledge that returns in the same cycle as the request, SHALL give a request-to-mem_ready latency of 6 cycles (1 accept + 4 beats + 1 RESP).
REQ-025 SHALL ignore bus_ack outside BEAT.
REQ-026 SHALL ignore changes on mem_addr and mem_wdata after acceptance.
REQ-027 For a write, mem_rdata SHALL keep its previous value.
REQ-028 SHALL keep mem_ready at 0 in IDLE and BEAT.

Reset
REQ-029 When proc_reset is high at a clock edge, SHALL force state to IDLE, beat to 0, and mem_ready, bus_req, bus_we to 0.
REQ-030 When proc_reset is high at a clock edge, SHALL clear bus_addr, bus_wdata, and mem_rdata to 0.
REQ-031 A reset during BEAT or RESP SHALL abort the transfer with no mem_ready pulse; bus_req SHALL be low in the cycle after the reset edge.

Configuration
REQ-032 With macro LINE_BUS_TIMEOUT_EN defined, SHALL add output bus_err (1 bit, sticky, cleared only by proc_reset) and a per-beat wait counter reset on each beat start.
REQ-033 With LINE_BUS_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYCLES without bus_ack, SHALL treat the beat as acknowledged, store a read word of 0x00000000, and set bus_err.
REQ-034 With LINE_BUS_TIMEOUT_EN undefined, SHALL have no bus_err port and no counter, and SHALL wait on a beat indefinitely.

Verification
REQ-035 Line read: reset, mem_read=1, mem_addr=0x0000010, bus_ack tied high, bus_rdata=0x11111111..0x44444444 -> bus_addr 0x40,0x41,0x42,0x43; mem_ready at cycle 6; mem_rdata=0x44444444_33333333_22222222_11111111.
REQ-036 Line write: mem_write=1, mem_addr=0x000000F, mem_wdata=0xDDDD..._CCCC..._BBBB..._AAAA..., bus_ack delayed 2 cycles per beat -> bus_we=1, bus_wdata AAAA..,BBBB..,CCCC..,DDDD.. at addr 0x3C..0x3F; one mem_ready pulse; mem_rdata unchanged.
REQ-037 Back-to-back: write completes, then mem_read asserted in the cycle after RESP -> new read accepted immediately, bus_we=0, no lost or duplicate beat.
REQ-038 Reset mid-burst: proc_reset high during beat 2 of a read -> bus_req=0 next cycle, mem_ready never pulses, mem_rdata=0.
REQ-039 With LINE_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, bus_ack never given on beat 1 -> beat 1 advances after 8 cycles, word 1=0x00000000, bus_err=1 until reset, mem_ready still pulses once.
